// File: rtl/uart_tx_stream.sv
// uart_tx_stream: UART transmitter fed by a valid/ready word stream.
// Frame = start bit, DATA_BITS payload bits LSB first, optional parity bit,
// one or two stop bits. Frames can follow each other with no idle gap.
// The serial line is driven from a register, one cycle behind the state.
module uart_tx_stream #(
  parameter int unsigned BIT_CYCLES = 234,   // clock cycles per serial bit, >= 2
  parameter int unsigned DATA_BITS  = 8,     // payload bits per frame, 5..9
  parameter logic [1:0]  PARITY     = 2'b00, // 00 none, 01 odd, 10 even, 11 none
  parameter logic        STOP_BITS  = 1'b0   // 0: one stop bit, 1: two stop bits
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned BAUD_W = $clog2(BIT_CYCLES);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic              PAR_EN    = (PARITY == 2'b01) || (PARITY == 2'b10);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]  word_q, word_d;
  logic                  tx_q, tx_d;

  logic bit_end;    // last cycle of the current bit period
  logic last_stop;  // currently sending the final stop bit
  logic accept;     // handshake completes on the coming edge

  assign bit_end = (baud_q == BAUD_LAST);
  assign accept  = tx_valid && tx_ready;
  assign tx      = tx_q;

  // State register.
  // NOTE: sequential state is always updated with <= so every register samples
  // pre-edge values; a blocking = here would make results depend on block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: walk start/data/parity/stop, chaining frames on accept.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_START;
      S_START:  if (bit_end) state_d = S_DATA;
      S_DATA:   if (bit_end && (bit_q == DATA_LAST)) state_d = PAR_EN ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (frame_done) state_d = accept ? S_START : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic: handshake, status flags and the next line level.
  always_comb begin
    last_stop  = (state_q == S_STOP) && (!STOP_BITS || (bit_q == BIT_W'(1)));
    frame_done = last_stop && bit_end;
    tx_ready   = (state_q == S_IDLE) || frame_done;
    busy       = (state_q != S_IDLE);
    tx_d       = 1'b1;
    unique case (state_q)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
      S_PARITY: tx_d = (PARITY == 2'b10) ? ^word_q : ~^word_q;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // Datapath next values: baud/bit counters, shift register and latched word.
  always_comb begin
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    word_d  = word_q;

    if (state_q == S_IDLE) begin
      baud_d = '0;
    end else if (bit_end) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + BAUD_W'(1);
    end

    unique case (state_q)
      S_IDLE:   bit_d = '0;
      S_START:  if (bit_end) bit_d = '0;  // cleared on entry to DATA
      S_DATA: begin
        if (bit_end) begin
          bit_d   = (bit_q == DATA_LAST) ? '0 : bit_q + BIT_W'(1);
          shift_d = shift_q >> 1;
        end
      end
      S_PARITY: bit_d = '0;
      S_STOP:   if (bit_end) bit_d = frame_done ? '0 : bit_q + BIT_W'(1);
      default:  bit_d = '0;
    endcase

    // Parity uses word_q, which stays intact while shift_q is consumed.
    if (accept) begin
      shift_d = tx_data;
      word_d  = tx_data;
    end
  end

  // Datapath registers and the registered serial line.
  // NOTE: the data registers are reset too; they are small, and a defined value
  // keeps the parity bit and line level free of X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Parametrised UART transmitter with a valid/ready input handshake, configurable word length, parity and stop-bit count. It sits between a byte/word producer (FIFO, command generator) and the `tx` pin. Back-to-back frames are sent with no idle gap. Every bit period is timed by an internal baud counter.

## Interface

- `BIT_CYCLES`, 234: clock cycles per serial bit; 27 MHz / 115200 baud. Legal range ≥ 2.
- `DATA_BITS`, 8: payload bits per frame, 5..9, sent LSB first.
- `PARITY`, 2'b00: 2'b00 none, 2'b01 odd, 2'b10 even, 2'b11 treated as none.
- `STOP_BITS`, 1'b0: 1'b0 one stop bit, 1'b1 two stop bits.

Ports:

- `clk`  in  1  system clock. All logic is clocked on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_data`  in  DATA_BITS  word to send. Sampled only on handshake.
- `tx_valid`  in  1  producer has a word on `tx_data`.
- `tx_ready`  out  1  block accepts a word this cycle.
- `tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  a frame is in progress.
- `frame_done`  out  1  one-cycle pulse in the final cycle of the last stop bit.

## Operation

- **Handshake:** a word is accepted when `tx_valid && tx_ready` at a rising edge of `clk`. `tx_data` is copied into the shift register on that edge. The producer may change `tx_data` afterwards.
- **When `tx_ready` is high:** it is combinational from state and counters, and is high in two cases.
  - In IDLE.
  - In the last `clk` cycle of the last stop bit.
- **State machine** (registered):
  - IDLE → START on accept.
  - START → DATA after BIT_CYCLES cycles.
  - DATA → PARITY after DATA_BITS bit periods, if parity is enabled.
  - DATA → STOP after DATA_BITS bit periods, if parity is disabled.
  - PARITY → STOP after one bit period.
  - STOP → START on accept in its final cycle.
  - STOP → IDLE otherwise, after 1 or 2 bit periods.
- **Line levels per state:**
  - IDLE: `tx` = 1.
  - START: `tx` = 0.
  - DATA: `tx` = shift register bit 0. The register shifts right once per bit period.
  - PARITY: `tx` = ^word for even parity, ~^word for odd parity. Parity is computed on the latched word, not the shifted copy.
  - STOP: `tx` = 1.
- **Baud counter:** width $clog2(BIT_CYCLES). Counts 0..BIT_CYCLES-1, then wraps to 0 and advances the bit.
- **Bit counter:** width $clog2(DATA_BITS+1). Cleared on entry to DATA.
- **Other outputs:**
  - `busy` = 1 in every state other than IDLE.
  - `frame_done` is high in the cycle where the baud counter = BIT_CYCLES-1 in the last stop bit.
- **`tx_valid` with `tx_ready` low:** ignored. The producer holds the word until the handshake.

## Timing

- **Reset** (`rst_n` low, asynchronous), effective immediately:
  - State and counters: state = IDLE, both counters = 0.
  - Outputs: `tx` = 1, `busy` = 0, `frame_done` = 0, `tx_ready` = 1.
- **Reset during a frame:** the frame is aborted with no further bits. `tx` returns high without glitching low.
- **Accept to start bit:** if the accept is at edge N, `tx` falls on edge N+1.
- **Bit periods:** each bit lasts exactly BIT_CYCLES cycles.
- **Frame length:** (1 + DATA_BITS + P + S) × BIT_CYCLES cycles.
  - P = 1 if parity is enabled, else 0.
  - S = 1 or 2 stop bits.
- **Back-to-back frames:** an accept in the final stop cycle starts the next start bit on the following edge, with zero idle cycles. `busy` stays high across the boundary.
- **Accept in the same cycle as `frame_done`:** legal. `frame_done` still pulses.
- **Output width and latency:** `tx_data` is exactly DATA_BITS wide, with no truncation logic. `tx` has one register of latency relative to state.

## Test plan

- **Reset values:** assert `rst_n` low mid-data-bit, BIT_CYCLES=4 → `tx`=1, `busy`=0, `tx_ready`=1 in the same cycle. The next frame after release is clean.
- **8N1 frame:** BIT_CYCLES=4, 8N1, send 0xA5 → `tx` = 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop). Each level is held 4 cycles, 40 cycles total. `frame_done` pulses once, at cycle 40.
- **Parity:** 8E1 with 0xA5 → parity bit 0. 8O1 with 0xA5 → parity bit 1. 7O2 with 0x41 → parity bit 1, two stop bits, 44 cycles.
- **Back-to-back frames:** `tx_valid` held high with words 0x00, 0xFF, 0x55 → three frames of 40 cycles each, no idle cycle between them. `tx_ready` is high only in cycles 40, 80 and 120.
- **Stall:** `tx_valid` asserted mid-frame, `tx_data` changed each cycle until the handshake → only the value present at the `tx_ready` cycle is transmitted.
- **Stretched period:** BIT_CYCLES=234, 5N1, 0x1F → start bit low for 234 cycles. The whole frame is 1638 cycles.
